// File: rtl/servo_pwm.sv
// servo_pwm: frame-synchronous servo pulse generator.
// An accepted angle becomes a pulse width that is held in a pending slot and
// applied only at the next frame boundary (count==0), so a frame never glitches.
// Optional build macro SERVO_SLEW_EN: width ramps toward the target by at most
// SLEW_MAX per frame instead of jumping straight to it.
module servo_pwm #(
  parameter logic [19:0] PULSE_MIN  = 20'd50000,
  parameter logic [19:0] ANGLE_STEP = 20'd278,
  parameter logic [7:0]  ANGLE_MAX  = 8'd180,
  parameter logic [19:0] SLEW_MAX   = 20'd5000
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [19:0] count,
  input  logic [7:0]  angle,
  input  logic        angle_valid,
  output logic        angle_ready,
  output logic        pwm_out,
  output logic        frame_start,
  output logic [19:0] width
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_e;

  state_e      state_q, state_d;
  logic        pending_full_q, pending_full_d;
  logic [19:0] pending_q, pending_d;
  logic [19:0] width_q, width_d;
  logic        pwm_q, pwm_d;
  logic        fstart_q, fstart_d;
  logic        ready_q, ready_d;
`ifdef SERVO_SLEW_EN
  logic [19:0] active_q, active_d;
`endif

  logic        boundary;
  logic        accept;
  logic [7:0]  angle_clamped;
  logic [19:0] target;

  assign boundary      = (count == 20'd0);
  assign accept        = angle_valid && ready_q;
  assign angle_clamped = (angle > ANGLE_MAX) ? ANGLE_MAX : angle;
  assign target        = PULSE_MIN + ({12'd0, angle_clamped} * ANGLE_STEP);

  // One slew step from cur toward tgt, landing exactly on tgt for the last step.
  function automatic logic [19:0] slew_step(input logic [19:0] cur,
                                            input logic [19:0] tgt);
    if (cur < tgt)
      slew_step = ((tgt - cur) > SLEW_MAX) ? cur + SLEW_MAX : tgt;
    else
      slew_step = ((cur - tgt) > SLEW_MAX) ? cur - SLEW_MAX : tgt;
  endfunction

  // Next-state: FSM, pending slot, boundary load and the registered pulse.
  always_comb begin
    state_d        = state_q;
    pending_full_d = pending_full_q;
    pending_d      = pending_q;
    width_d        = width_q;
    fstart_d       = boundary;
`ifdef SERVO_SLEW_EN
    active_d       = active_q;
`endif

    if (boundary && pending_full_q) begin
      pending_full_d = 1'b0;
      state_d        = RUN;
`ifdef SERVO_SLEW_EN
      active_d = pending_q;
      width_d  = (state_q == RUN) ? slew_step(width_q, pending_q) : PULSE_MIN;
`else
      width_d  = pending_q;
`endif
    end
`ifdef SERVO_SLEW_EN
    else if (boundary && (state_q == RUN)) begin
      width_d = slew_step(width_q, active_q);
    end
`endif

    // ready_q implies the slot is empty, so this never collides with a load.
    if (accept) begin
      pending_d      = target;
      pending_full_d = 1'b1;
      if (state_q == IDLE) state_d = ARMED;
    end

    ready_d = ~pending_full_d;
    // Compare against the width that will be live next cycle so the load frame
    // is covered from count 0 onward.
    pwm_d   = (state_d == RUN) && (count < width_d);
  end

  // State register; reset clears everything and reopens the pending slot.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pending_full_q <= 1'b0;
      pending_q      <= 20'd0;
      width_q        <= 20'd0;
      pwm_q          <= 1'b0;
      fstart_q       <= 1'b0;
      ready_q        <= 1'b1;
`ifdef SERVO_SLEW_EN
      active_q       <= 20'd0;
`endif
    end else begin
      state_q        <= state_d;
      pending_full_q <= pending_full_d;
      pending_q      <= pending_d;
      width_q        <= width_d;
      pwm_q          <= pwm_d;
      fstart_q       <= fstart_d;
      ready_q        <= ready_d;
`ifdef SERVO_SLEW_EN
      active_q       <= active_d;
`endif
    end
  end

  assign angle_ready = ready_q;
  assign pwm_out     = pwm_q;
  assign frame_start = fstart_q;
  assign width       = width_q;

endmodule

// File: tb/tb_servo_pwm.sv
// Directed bench for servo_pwm; count is driven by the bench so whole frames
// can be skipped through quickly.
module tb_servo_pwm;
  logic        clk_in = 1'b0;
  logic        rst_n;
  logic [19:0] count;
  logic [7:0]  angle;
  logic        angle_valid;
  logic        angle_ready;
  logic        pwm_out;
  logic        frame_start;
  logic [19:0] width;

  int n_chk  = 0;
  int n_fail = 0;

  servo_pwm dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .count       (count),
    .angle       (angle),
    .angle_valid (angle_valid),
    .angle_ready (angle_ready),
    .pwm_out     (pwm_out),
    .frame_start (frame_start),
    .width       (width)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Present count for one rising edge, then sample 1 ns later.
  task automatic step(input logic [19:0] c);
    count = c;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; count = 20'd7; angle = 8'd0; angle_valid = 1'b0;
    #12;
    chk("rst_pwm",    32'(pwm_out),     32'd0);
    chk("rst_fstart", 32'(frame_start), 32'd0);
    chk("rst_width",  32'(width),       32'd0);
    chk("rst_ready",  32'(angle_ready), 32'd1);
    @(negedge clk_in); rst_n = 1'b1;

`ifdef SERVO_SLEW_EN
    angle = 8'd180; angle_valid = 1'b1;
    step(20'd5);
    chk("sl_ready0", 32'(angle_ready), 32'd0);
    angle_valid = 1'b0;
    step(20'd0);
    chk("sl_load", 32'(width), 32'd50000);
    for (int k = 1; k <= 10; k++) begin
      step(20'd0);
      chk("sl_step", 32'(width), 32'(50000 + 5000 * k));
    end
    step(20'd0);
    chk("sl_last", 32'(width), 32'd100040);
    step(20'd0);
    chk("sl_hold", 32'(width), 32'd100040);
    step(20'd99);
    chk("sl_pwm", 32'(pwm_out), 32'd1);
`else
    // angle 90 accepted mid-frame, applied at the next boundary
    angle = 8'd90; angle_valid = 1'b1;
    step(20'd500);
    chk("a90_ready0", 32'(angle_ready), 32'd0);
    chk("a90_w_pre",  32'(width),       32'd0);
    angle_valid = 1'b0;
    step(20'd501);
    chk("armed_pwm0", 32'(pwm_out), 32'd0);
    step(20'd0);
    chk("a90_fstart", 32'(frame_start), 32'd1);
    chk("a90_width",  32'(width),       32'd75020);
    chk("a90_ready1", 32'(angle_ready), 32'd1);
    chk("a90_pwm_c0", 32'(pwm_out),     32'd1);
    step(20'd1);
    chk("fstart_1cy", 32'(frame_start), 32'd0);
    step(20'd75019);
    chk("a90_pwm_hi", 32'(pwm_out), 32'd1);
    step(20'd75020);
    chk("a90_pwm_lo", 32'(pwm_out), 32'd0);
    step(20'd999999);
    chk("a90_pwm_end", 32'(pwm_out), 32'd0);

    // clamp 200 -> 180; valid held while slot is full is ignored
    angle = 8'd200; angle_valid = 1'b1;
    step(20'd10);
    chk("a200_ready0", 32'(angle_ready), 32'd0);
    chk("a200_w_old",  32'(width),       32'd75020);
    angle = 8'd0;
    step(20'd11);
    chk("hold_ready0", 32'(angle_ready), 32'd0);
    step(20'd0);
    chk("clamp_width", 32'(width),       32'd100040);
    chk("hold_ready1", 32'(angle_ready), 32'd1);
    step(20'd1);
    chk("a0_ready0", 32'(angle_ready), 32'd0);
    angle_valid = 1'b0;
    step(20'd100039);
    chk("clamp_pwm_hi", 32'(pwm_out), 32'd1);
    step(20'd100040);
    chk("clamp_pwm_lo", 32'(pwm_out), 32'd0);
    step(20'd0);
    chk("a0_width", 32'(width), 32'd50000);
    step(20'd49999);
    chk("a0_pwm_hi", 32'(pwm_out), 32'd1);
    step(20'd50000);
    chk("a0_pwm_lo", 32'(pwm_out), 32'd0);

    // accept coincident with a boundary waits one frame
    angle = 8'd90; angle_valid = 1'b1;
    step(20'd0);
    chk("coin_fstart", 32'(frame_start), 32'd1);
    chk("coin_w_same", 32'(width),       32'd50000);
    chk("coin_ready0", 32'(angle_ready), 32'd0);
    angle_valid = 1'b0;
    step(20'd5);
    chk("coin_w_mid", 32'(width), 32'd50000);
    step(20'd0);
    chk("coin_w_next", 32'(width), 32'd75020);

    // count skipping 0 must not load the pending angle
    angle = 8'd180; angle_valid = 1'b1;
    step(20'd7);
    angle_valid = 1'b0;
    step(20'd999999);
    step(20'd3);
    chk("skip_width", 32'(width),       32'd75020);
    chk("skip_pwm",   32'(pwm_out),     32'd1);
    chk("skip_ready", 32'(angle_ready), 32'd0);
    step(20'd0);
    chk("skip_load", 32'(width), 32'd100040);

    // asynchronous reset mid-pulse
    step(20'd30000);
    chk("pre_rst_pwm", 32'(pwm_out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pwm",   32'(pwm_out),     32'd0);
    chk("arst_width", 32'(width),       32'd0);
    chk("arst_ready", 32'(angle_ready), 32'd1);
    @(negedge clk_in); rst_n = 1'b1;
    angle = 8'd0; angle_valid = 1'b1;
    step(20'd0);
    chk("post_rst_acc", 32'(angle_ready), 32'd0);
    chk("post_rst_w",   32'(width),       32'd0);
    angle_valid = 1'b0;
    step(20'd100);
    chk("post_rst_pwm", 32'(pwm_out), 32'd0);
    step(20'd0);
    chk("post_rst_load", 32'(width), 32'd50000);
    step(20'd10);
    chk("post_rst_pwm1", 32'(pwm_out), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/servo_pwm.md
SERVO_PWM -- requirements
Module: servo_pwm

Interface
REQ-001 Parameter PULSE_MIN, default 20'd50000, pulse width in cycles for angle 0 (1 ms at 50 MHz).
REQ-002 Parameter ANGLE_STEP, default 20'd278, cycles added per degree.
REQ-003 Parameter ANGLE_MAX, default 8'd180, largest accepted angle; larger values clamp to it.
REQ-004 Parameter SLEW_MAX, default 20'd5000, maximum width change per frame when SERVO_SLEW_EN is defined.
REQ-005 clk_in  input  1  system clock, 50 MHz, rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 count  input  20  free-running frame count from the upstream period counter, 0..1000000, wraps to 0.
REQ-008 angle  input  8  requested servo angle in degrees.
REQ-009 angle_valid  input  1  angle is presented.
REQ-010 angle_ready  output  1  pending slot is empty and can accept an angle.
REQ-011 pwm_out  output  1  servo control pulse.
REQ-012 frame_start  output  1  one-cycle pulse when count==0 is seen.
REQ-013 width  output  20  pulse width currently applied, in cycles.

Function
REQ-014 Angle transfer SHALL occur on a rising clk_in edge where angle_valid and angle_ready are both 1.
REQ-015 angle_ready SHALL be registered and equal to the inverse of pending_full: 1 after reset, 0 in the cycle after an accept, and 1 again in the cycle after the next frame boundary.
REQ-016 On accept, target = PULSE_MIN + min(angle, ANGLE_MAX)*ANGLE_STEP, computed in 20 bits, SHALL be stored in the pending register.
REQ-017 Frame boundary is defined as count==0; the block SHALL register frame_start=1 for exactly that one cycle.
REQ-018 At a frame boundary with pending_full=1, pending SHALL move to the active target and pending_full SHALL clear. Width changes only at frame boundaries, so there is never a glitch mid-frame.
REQ-019 State machine: IDLE (no angle since reset), ARMED (pending_full, waiting for boundary), RUN (active target valid).
REQ-020 Transitions: IDLE->ARMED on accept; ARMED->RUN at the next boundary; RUN stays RUN. A new accept in RUN sets pending_full without leaving RUN.
REQ-021 pwm_out SHALL be registered: pwm_out = (state==RUN) && (count < width), which gives 1 cycle latency from count.
REQ-022 In IDLE and ARMED, pwm_out SHALL be 0 and width SHALL be 0.
REQ-023 An angle accepted in the same cycle as a boundary SHALL NOT apply until the following boundary.
REQ-024 If count skips 0 (upstream glitch), no load SHALL occur and pwm_out SHALL still follow the comparison.
REQ-025 angle=0 SHALL give width 50000; angle=180 SHALL give 100040; angle>=181 SHALL give 100040.

Reset
REQ-026 While rst_n=0, all outputs SHALL be immediately forced to: pwm_out=0, frame_start=0, width=0, angle_ready=1, state=IDLE, pending_full=0.
REQ-027 Reset asserted mid-pulse SHALL drop pwm_out asynchronously and discard any pending angle.
REQ-028 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-029 Macro SERVO_SLEW_EN: when defined, at each boundary in RUN, width SHALL move toward the target by at most SLEW_MAX, with the last step landing exactly on the target. On the ARMED->RUN load, width SHALL start at PULSE_MIN and then slew toward the target.
REQ-030 Without SERVO_SLEW_EN, width SHALL equal the active target immediately at the load boundary.

Verification
REQ-031 Reset, then angle=90 accepted at count=500 -> angle_ready=0 next cycle; at the next count==0, width=75020; pwm_out is high for count 0..75019, with 1 cycle lag.
REQ-032 angle=200 -> width=100040 (clamped); angle=0 -> width=50000.
REQ-033 angle_valid held while angle_ready=0 -> no accept; second angle accepted only after the boundary re-raises angle_ready.
REQ-034 rst_n pulled low at count=30000 while pwm_out=1 -> pwm_out=0 asynchronously, state IDLE, pwm_out stays 0 in the following frames until a new angle is accepted and its boundary passes.
REQ-035 Accept coincident with count==0 -> width unchanged this frame, applied at the next boundary.
REQ-036 With SERVO_SLEW_EN, angle=180 from reset -> width 50000, 55000, ..., 100000, 100040 over successive frames.
